// File: rtl/pkt_fifo_pkg.sv
// Shared types and word-layout constants for the single-clock packet FIFO.
// Stored word is {sop, data, eop}: eop in bit 0, sop in the top bit.
package pkt_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IN_PKT = 2'd1,
        DROP   = 2'd2
    } wr_state_e;

    localparam int EOP_BIT = 0;

    function automatic int sop_bit(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/pkt_sync_fifo_if.sv
// Write, read and status bundle of the packet FIFO; master is the client side.
// The FIFO itself connects through the slave modport.
interface pkt_sync_fifo_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int PKT_CNT_WIDTH = ADDR_WIDTH + 1
);
    logic                     wr_en;
    logic                     wr_sop;
    logic                     wr_eop;
    logic [DATA_WIDTH-1:0]    wr_data;
    logic                     rd_en;
    logic                     rd_valid;
    logic [DATA_WIDTH-1:0]    rd_data;
    logic                     rd_sop;
    logic                     rd_eop;
    logic                     full;
    logic                     almost_full;
    logic                     empty;
    logic                     almost_empty;
    logic [ADDR_WIDTH:0]      wr_lvl;
    logic [ADDR_WIDTH:0]      rd_lvl;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt;
    logic                     overflow;
    logic                     underflow;
    logic                     pkt_drop;
    logic                     frm_err;

    modport master (
        output wr_en, wr_sop, wr_eop, wr_data, rd_en,
        input  rd_valid, rd_data, rd_sop, rd_eop, full, almost_full, empty,
               almost_empty, wr_lvl, rd_lvl, pkt_cnt, overflow, underflow,
               pkt_drop, frm_err
    );

    modport slave (
        input  wr_en, wr_sop, wr_eop, wr_data, rd_en,
        output rd_valid, rd_data, rd_sop, rd_eop, full, almost_full, empty,
               almost_empty, wr_lvl, rd_lvl, pkt_cnt, overflow, underflow,
               pkt_drop, frm_err
    );
endinterface

// File: rtl/pkt_fifo_mem.sv
// Simple dual-port RAM: synchronous write, registered read, no reset.
// Read data appears one cycle after rd_en; no backpressure.
module pkt_fifo_mem #(
    parameter int WIDTH      = 34,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_dat
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat = rd_dat_q;
endmodule

// File: rtl/pkt_sync_fifo.sv
// Single-clock packet FIFO with cut-through or store-and-forward visibility and drop-by-rewind.
// Writes land the same edge; reads return one cycle after rd_en; full refuses writes, empty refuses reads.
module pkt_sync_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int ADDR_WIDTH    = $clog2(DEPTH),
    parameter int ALMOST        = 3,
    parameter int PKT_CNT_WIDTH = ADDR_WIDTH + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sw_rst,
    input  logic           sf_en,
    pkt_sync_fifo_if.slave bus
);
    localparam int PW      = ADDR_WIDTH + 1;
    localparam int WW      = DATA_WIDTH + 2;
    localparam int SOP_BIT = sop_bit(DATA_WIDTH);
    localparam logic [PW-1:0] DEPTH_LVL = PW'(DEPTH);
    localparam logic [PW-1:0] AF_LVL    = PW'(DEPTH - ALMOST);
    localparam logic [PW-1:0] AE_LVL    = PW'(ALMOST);

    wr_state_e                state_q, state_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
    logic rd_valid_q, rd_valid_d, overflow_q, overflow_d, underflow_q, underflow_d;
    logic pkt_drop_q, pkt_drop_d, frm_err_q, frm_err_d;

    logic [PW-1:0] wr_lvl, rd_lvl, vis_ptr, base;
    logic          full, empty, start, cont, base_full, commit, mem_we, rd_go, rd_eop_go;
    logic [PW-1:0] mem_wptr;
    logic [WW-1:0] mem_rdat;
    // eop copy kept in flops so pkt_cnt can drop on the same edge the eop word is read
    logic [DEPTH-1:0] eop_tag;

    assign vis_ptr = sf_en ? cm_ptr_q : wr_ptr_q;
    assign wr_lvl  = wr_ptr_q - rd_ptr_q;
    assign rd_lvl  = vis_ptr - rd_ptr_q;
    assign full    = (wr_lvl == DEPTH_LVL);
    assign empty   = (rd_lvl == '0);

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cm_ptr_d   = cm_ptr_q;
        mem_we     = 1'b0;
        mem_wptr   = wr_ptr_q;
        commit     = 1'b0;
        overflow_d = 1'b0;
        pkt_drop_d = 1'b0;
        frm_err_d  = 1'b0;
        start      = 1'b0;
        cont       = 1'b0;
        base       = wr_ptr_q;
        if (bus.wr_en) begin
            case (state_q)
                IDLE: begin
                    if (bus.wr_sop) start = 1'b1;
                    else            frm_err_d = 1'b1;
                end
                IN_PKT: begin
                    if (bus.wr_sop && sf_en) begin
                        frm_err_d  = 1'b1;
                        pkt_drop_d = 1'b1;
                        base       = cm_ptr_q;
                        start      = 1'b1;
                    end else begin
                        frm_err_d = bus.wr_sop;
                        cont      = 1'b1;
                    end
                end
                DROP: begin
                    if (bus.wr_sop)      start   = 1'b1;
                    else if (bus.wr_eop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        // a restarted packet sees the space freed by its own rewind
        base_full = ((base - rd_ptr_q) == DEPTH_LVL);
        if (start) begin
            wr_ptr_d = base;
            if (base_full) begin
                overflow_d = 1'b1;
                pkt_drop_d = 1'b1;
                state_d    = bus.wr_eop ? IDLE : DROP;
            end else begin
                mem_we   = 1'b1;
                mem_wptr = base;
                wr_ptr_d = base + 1'b1;
                commit   = bus.wr_eop;
                state_d  = bus.wr_eop ? IDLE : IN_PKT;
            end
        end
        if (cont) begin
            if (!full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                commit   = bus.wr_eop;
                if (bus.wr_eop) state_d = IDLE;
            end else begin
                overflow_d = 1'b1;
                if (sf_en) begin
                    pkt_drop_d = 1'b1;
                    wr_ptr_d   = cm_ptr_q;
                    state_d    = bus.wr_eop ? IDLE : DROP;
                end else if (bus.wr_eop) begin
                    state_d = IDLE;
                end
            end
        end
        if (commit || !sf_en) cm_ptr_d = wr_ptr_d;
    end

    always_comb begin
        rd_go       = bus.rd_en && !empty;
        rd_ptr_d    = rd_go ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_valid_d  = rd_go;
        underflow_d = bus.rd_en && empty;
        rd_eop_go   = rd_go && eop_tag[rd_ptr_q[ADDR_WIDTH-1:0]];
        pkt_cnt_d   = pkt_cnt_q;
        if (sf_en) begin
            case ({commit, rd_eop_go})
                2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
                2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
                default: pkt_cnt_d = pkt_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || sw_rst) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            pkt_drop_q  <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            pkt_drop_q  <= pkt_drop_d;
            frm_err_q   <= frm_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) eop_tag[mem_wptr[ADDR_WIDTH-1:0]] <= bus.wr_eop;
    end

    pkt_fifo_mem #(
        .WIDTH      (WW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (mem_wptr[ADDR_WIDTH-1:0]),
        .wr_dat  ({bus.wr_sop, bus.wr_data, bus.wr_eop}),
        .rd_en   (rd_go),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_dat  (mem_rdat)
    );

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = rd_valid_q ? mem_rdat[DATA_WIDTH:1] : '0;
    assign bus.rd_sop       = rd_valid_q & mem_rdat[SOP_BIT];
    assign bus.rd_eop       = rd_valid_q & mem_rdat[EOP_BIT];
    assign bus.full         = full;
    assign bus.almost_full  = (wr_lvl >= AF_LVL);
    assign bus.empty        = empty;
    assign bus.almost_empty = (rd_lvl <= AE_LVL);
    assign bus.wr_lvl       = wr_lvl;
    assign bus.rd_lvl       = rd_lvl;
    assign bus.pkt_cnt      = pkt_cnt_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
    assign bus.pkt_drop     = pkt_drop_q;
    assign bus.frm_err      = frm_err_q;
endmodule

// File: tb/tb_pkt_sync_fifo.sv
// Bench for pkt_sync_fifo: per-cycle vector table plus hand sequences for overflow, wrap and soft reset.
// Read data is checked against a scoreboard queue filled when words are driven.
module tb_pkt_sync_fifo;
    localparam int DW     = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int ALMOST = 3;
    localparam int PCW    = 6;

    typedef struct {
        logic sf, we, sop, eop, re, keep;
        int   wl, rl, pc;
        logic rv, ovf, drop, ferr, udf;
    } vec_t;

    typedef struct packed {
        logic          sop;
        logic [DW-1:0] data;
        logic          eop;
    } word_t;

    logic clk = 1'b0;
    logic rst, sw_rst, sf_en;
    logic mon_en = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    word_t sb_q[$];
    vec_t  vt[$];

    always #5 clk = ~clk;

    pkt_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_CNT_WIDTH(PCW)) bus ();

    pkt_sync_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ADDR_WIDTH    (AW),
        .ALMOST        (ALMOST),
        .PKT_CNT_WIDTH (PCW)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .sw_rst (sw_rst),
        .sf_en  (sf_en),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_lvl(input string tag, input int wl, input int rl, input int pc);
        chk({tag, "_wr_lvl"}, 64'(bus.wr_lvl), 64'(wl));
        chk({tag, "_rd_lvl"}, 64'(bus.rd_lvl), 64'(rl));
        chk({tag, "_pkt_cnt"}, 64'(bus.pkt_cnt), 64'(pc));
        chk({tag, "_full"}, 64'(bus.full), 64'(wl == DEPTH));
        chk({tag, "_almost_full"}, 64'(bus.almost_full), 64'(wl >= DEPTH - ALMOST));
        chk({tag, "_empty"}, 64'(bus.empty), 64'(rl == 0));
        chk({tag, "_almost_empty"}, 64'(bus.almost_empty), 64'(rl <= ALMOST));
    endtask

    task automatic chk_pulses(input string tag, input logic ovf, input logic drop,
                              input logic ferr, input logic udf);
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(ovf));
        chk({tag, "_pkt_drop"}, 64'(bus.pkt_drop), 64'(drop));
        chk({tag, "_frm_err"}, 64'(bus.frm_err), 64'(ferr));
        chk({tag, "_underflow"}, 64'(bus.underflow), 64'(udf));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic sop, input logic eop,
                         input logic [DW-1:0] d, input logic re, input logic keep);
        bus.wr_en   = we;
        bus.wr_sop  = sop;
        bus.wr_eop  = eop;
        bus.wr_data = d;
        bus.rd_en   = re;
        if (keep) sb_q.push_back({sop, d, eop});
    endtask

    function automatic vec_t mkv(input logic sf, input logic we, input logic sop, input logic eop,
                                 input logic re, input logic keep, input int wl, input int rl,
                                 input int pc, input logic rv, input logic ovf, input logic drop,
                                 input logic ferr, input logic udf);
        vec_t v;
        v.sf = sf; v.we = we; v.sop = sop; v.eop = eop; v.re = re; v.keep = keep;
        v.wl = wl; v.rl = rl; v.pc = pc;
        v.rv = rv; v.ovf = ovf; v.drop = drop; v.ferr = ferr; v.udf = udf;
        return v;
    endfunction

    always @(negedge clk) begin
        word_t w;
        if (mon_en && bus.rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rd_valid", 64'(1), 64'(0));
            end else begin
                w = sb_q.pop_front();
                chk("rd_data", 64'(bus.rd_data), 64'(w.data));
                chk("rd_sop", 64'(bus.rd_sop), 64'(w.sop));
                chk("rd_eop", 64'(bus.rd_eop), 64'(w.eop));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          sf we sop eop re keep  wl rl pc  rv ovf drp fer udf
        // SF packet A0..A3 with rd_en held high
        vt.push_back(mkv(1, 1, 1, 0, 1, 1,  1, 0, 0,  0, 0, 0, 0, 1));
        vt.push_back(mkv(1, 1, 0, 0, 1, 1,  2, 0, 0,  0, 0, 0, 0, 1));
        vt.push_back(mkv(1, 1, 0, 0, 1, 1,  3, 0, 0,  0, 0, 0, 0, 1));
        vt.push_back(mkv(1, 1, 0, 1, 1, 1,  4, 4, 1,  0, 0, 0, 0, 1));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  3, 3, 1,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  2, 2, 1,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  1, 1, 1,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
        // SF: 3 words of B, then a new sop restarts at the committed pointer
        vt.push_back(mkv(1, 1, 1, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(1, 1, 0, 0, 0, 0,  2, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(1, 1, 0, 0, 0, 0,  3, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(1, 1, 1, 0, 0, 1,  1, 0, 0,  0, 0, 1, 1, 0));
        vt.push_back(mkv(1, 1, 0, 1, 0, 1,  2, 2, 1,  0, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  1, 1, 1,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
        vt.push_back(mkv(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
        // CT: single-word packet, stray word, sop inside a packet
        vt.push_back(mkv(0, 1, 1, 1, 0, 1,  1, 1, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(0, 1, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 0));
        vt.push_back(mkv(0, 1, 1, 0, 0, 1,  1, 1, 0,  0, 0, 0, 0, 0));
        vt.push_back(mkv(0, 1, 1, 1, 1, 1,  1, 1, 0,  1, 0, 0, 1, 0));
        vt.push_back(mkv(0, 0, 0, 0, 1, 0,  0, 0, 0,  1, 0, 0, 0, 0));
        vt.push_back(mkv(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0, 0));

        rst    = 1'b1;
        sw_rst = 1'b0;
        sf_en  = 1'b1;
        drive(0, 0, 0, '0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_lvl("reset", 0, 0, 0);
        chk_pulses("reset", 0, 0, 0, 0);
        chk("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("reset_rd_data", 64'(bus.rd_data), 64'(0));
        mon_en = 1'b1;

        foreach (vt[i]) begin
            sf_en = vt[i].sf;
            drive(vt[i].we, vt[i].sop, vt[i].eop, 32'hA000_0000 + DW'(i), vt[i].re, vt[i].keep);
            tick();
            chk_lvl($sformatf("vec%0d", i), vt[i].wl, vt[i].rl, vt[i].pc);
            chk_pulses($sformatf("vec%0d", i), vt[i].ovf, vt[i].drop, vt[i].ferr, vt[i].udf);
            chk($sformatf("vec%0d_rd_valid", i), 64'(bus.rd_valid), 64'(vt[i].rv));
        end

        // SF overflow: 40-word packet into 32 entries
        sf_en = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            drive(1, k == 1, k == 40, 32'hB000_0000 + DW'(k), 0, 0);
            tick();
            chk($sformatf("ovf_w%0d_wr_lvl", k), 64'(bus.wr_lvl), 64'(k <= 32 ? k : 0));
            chk($sformatf("ovf_w%0d_overflow", k), 64'(bus.overflow), 64'(k == 33));
            chk($sformatf("ovf_w%0d_pkt_drop", k), 64'(bus.pkt_drop), 64'(k == 33));
            if (k == 28 || k == 29 || k == 32)
                chk_lvl($sformatf("ovf_w%0d", k), k, 0, 0);
        end
        drive(1, 1, 0, 32'hE000_0000, 0, 1);
        tick();
        drive(1, 0, 1, 32'hE000_0001, 0, 1);
        tick();
        chk_lvl("after_ovf_pkt", 2, 2, 1);
        drive(0, 0, 0, '0, 1, 0);
        tick();
        tick();
        drive(0, 0, 0, '0, 0, 0);
        tick();
        chk_lvl("after_ovf_drain", 0, 0, 0);

        // pointer wrap: 100 single-word packets, each read on the following cycle
        for (int k = 0; k < 100; k++) begin
            drive(1, 1, 1, 32'hC000_0000 + DW'(k), k > 0, 1);
            tick();
            chk($sformatf("wrap%0d_full", k), 64'(bus.full), 64'(0));
            chk($sformatf("wrap%0d_rd_lvl_le1", k), 64'(bus.rd_lvl <= 1), 64'(1));
            chk($sformatf("wrap%0d_almost_empty", k), 64'(bus.almost_empty), 64'(1));
        end
        drive(0, 0, 0, '0, 1, 0);
        tick();
        drive(0, 0, 0, '0, 0, 0);
        tick();
        chk_lvl("wrap_done", 0, 0, 0);

        // soft reset after 2 of 5 words
        drive(1, 1, 0, 32'hF000_0000, 0, 0);
        tick();
        drive(1, 0, 0, 32'hF000_0001, 0, 0);
        tick();
        drive(0, 0, 0, '0, 0, 0);
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk_lvl("swrst", 0, 0, 0);
        chk_pulses("swrst", 0, 0, 0, 0);
        drive(1, 1, 0, 32'hD000_0000, 0, 1);
        tick();
        chk("swrst_g0_frm_err", 64'(bus.frm_err), 64'(0));
        drive(1, 0, 0, 32'hD000_0001, 0, 1);
        tick();
        drive(1, 0, 1, 32'hD000_0002, 0, 1);
        tick();
        chk_lvl("swrst_g_committed", 3, 3, 1);
        drive(0, 0, 0, '0, 1, 0);
        tick();
        tick();
        tick();
        chk_lvl("swrst_g_drained", 0, 0, 0);
        tick();
        chk_pulses("swrst_udf", 0, 0, 0, 1);
        chk("swrst_udf_rd_valid", 64'(bus.rd_valid), 64'(0));
        drive(0, 0, 0, '0, 0, 0);
        tick();
        chk_pulses("swrst_udf_end", 0, 0, 0, 0);

        tick();
        chk("scoreboard_leftover", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
